// File: rtl/axil_register_slice.sv
// AXI-Lite register slice: each of the five channels is independently a bypass,
// a forward register, or a skid buffer with a registered upstream ready.

module axil_reg_slice_ch #(
  parameter int WIDTH = 8,
  parameter int MODE  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  if (MODE == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_data  = in_data;
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
  end else if (MODE == 1) begin : g_fwd
    logic             vld;
    logic [WIDTH-1:0] data;
    assign in_ready = !vld || out_ready;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld  <= 1'b0;
        data <= '0;
      end else if (in_ready) begin
        vld  <= in_valid;
        data <= in_valid ? in_data : '0;
      end
    end
    assign out_valid = vld;
    assign out_data  = data;
  end else if (MODE == 2) begin : g_skid
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t           state, state_nxt;
    logic             rdy;
    logic             accept, take;
    logic [WIDTH-1:0] out_reg, skid_reg, out_nxt, skid_nxt;

    assign accept = in_valid && rdy;
    assign take   = (state != EMPTY) && out_ready;

    always_comb begin
      state_nxt = state;
      out_nxt   = out_reg;
      skid_nxt  = skid_reg;
      case (state)
        EMPTY: if (accept) begin
          state_nxt = ONE;
          out_nxt   = in_data;
        end
        ONE: begin
          if (accept && !take) begin
            state_nxt = TWO;
            skid_nxt  = in_data;
          end else if (accept && take) begin
            out_nxt = in_data;
          end else if (take) begin
            state_nxt = EMPTY;
            out_nxt   = '0;
          end
        end
        TWO: if (take) begin
          state_nxt = ONE;
          out_nxt   = skid_reg;
          skid_nxt  = '0;
        end
        default: state_nxt = EMPTY;
      endcase
    end

    // Ready is a flop so no valid/ready pair has a combinational path.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state    <= EMPTY;
        rdy      <= 1'b0;
        out_reg  <= '0;
        skid_reg <= '0;
      end else begin
        state    <= state_nxt;
        rdy      <= (state_nxt != TWO);
        out_reg  <= out_nxt;
        skid_reg <= skid_nxt;
      end
    end

    assign in_ready  = rdy;
    assign out_valid = (state != EMPTY);
    assign out_data  = out_reg;
  end else begin : g_bad_mode
    $error("axil_reg_slice_ch: MODE must be 0, 1 or 2");
  end
endmodule

module axil_register_slice #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int AW_MODE    = 2,
  parameter int W_MODE     = 2,
  parameter int B_MODE     = 1,
  parameter int AR_MODE    = 2,
  parameter int R_MODE     = 2
) (
  input  logic                  aclk,
  input  logic                  arst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);
  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_dw
    $error("axil_register_slice: DATA_WIDTH must be 8, 16, 32 or 64");
  end
  if (AW_MODE < 0 || AW_MODE > 2 || W_MODE < 0 || W_MODE > 2 || B_MODE < 0 || B_MODE > 2 ||
      AR_MODE < 0 || AR_MODE > 2 || R_MODE < 0 || R_MODE > 2) begin : g_bad_mode
    $error("axil_register_slice: channel MODE must be 0, 1 or 2");
  end

  // B and R flow slave->master of the AXI link, so their "in" side is the m_ port.
  axil_reg_slice_ch #(.WIDTH(ADDR_WIDTH + 3), .MODE(AW_MODE)) u_aw (
    .clk(aclk), .rst(arst),
    .in_data({s_axil_awprot, s_axil_awaddr}), .in_valid(s_axil_awvalid), .in_ready(s_axil_awready),
    .out_data({m_axil_awprot, m_axil_awaddr}), .out_valid(m_axil_awvalid), .out_ready(m_axil_awready));

  axil_reg_slice_ch #(.WIDTH(DATA_WIDTH + STRB_WIDTH), .MODE(W_MODE)) u_w (
    .clk(aclk), .rst(arst),
    .in_data({s_axil_wstrb, s_axil_wdata}), .in_valid(s_axil_wvalid), .in_ready(s_axil_wready),
    .out_data({m_axil_wstrb, m_axil_wdata}), .out_valid(m_axil_wvalid), .out_ready(m_axil_wready));

  axil_reg_slice_ch #(.WIDTH(2), .MODE(B_MODE)) u_b (
    .clk(aclk), .rst(arst),
    .in_data(m_axil_bresp), .in_valid(m_axil_bvalid), .in_ready(m_axil_bready),
    .out_data(s_axil_bresp), .out_valid(s_axil_bvalid), .out_ready(s_axil_bready));

  axil_reg_slice_ch #(.WIDTH(ADDR_WIDTH + 3), .MODE(AR_MODE)) u_ar (
    .clk(aclk), .rst(arst),
    .in_data({s_axil_arprot, s_axil_araddr}), .in_valid(s_axil_arvalid), .in_ready(s_axil_arready),
    .out_data({m_axil_arprot, m_axil_araddr}), .out_valid(m_axil_arvalid), .out_ready(m_axil_arready));

  axil_reg_slice_ch #(.WIDTH(DATA_WIDTH + 2), .MODE(R_MODE)) u_r (
    .clk(aclk), .rst(arst),
    .in_data({m_axil_rresp, m_axil_rdata}), .in_valid(m_axil_rvalid), .in_ready(m_axil_rready),
    .out_data({s_axil_rresp, s_axil_rdata}), .out_valid(s_axil_rvalid), .out_ready(s_axil_rready));
endmodule

// File: tb/tb_axil_register_slice.sv
// Directed bench for axil_register_slice: AW/W/AR skid, B forward register, R bypass.

module tb_axil_register_slice;
  logic        aclk = 1'b0;
  logic        arst = 1'b1;
  logic [31:0] s_axil_awaddr = '0, s_axil_wdata = '0, s_axil_araddr = '0, s_axil_rdata;
  logic [2:0]  s_axil_awprot = '0, s_axil_arprot = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        s_axil_awvalid = 0, s_axil_awready, s_axil_wvalid = 0, s_axil_wready;
  logic [1:0]  s_axil_bresp, s_axil_rresp;
  logic        s_axil_bvalid, s_axil_bready = 0, s_axil_arvalid = 0, s_axil_arready;
  logic        s_axil_rvalid, s_axil_rready = 0;
  logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata = '0;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_awvalid, m_axil_awready = 0, m_axil_wvalid, m_axil_wready = 0;
  logic [1:0]  m_axil_bresp = '0, m_axil_rresp = '0;
  logic        m_axil_bvalid = 0, m_axil_bready, m_axil_arvalid, m_axil_arready = 0;
  logic        m_axil_rvalid = 0, m_axil_rready;

  int checks = 0;
  int errors = 0;
  logic [31:0] aw_out[$], w_out[$], ar_out[$];
  logic [1:0]  b_out[$];

  always #5 aclk = ~aclk;

  axil_register_slice #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4),
    .AW_MODE(2), .W_MODE(2), .B_MODE(1), .AR_MODE(2), .R_MODE(0)
  ) dut (
    .aclk(aclk), .arst(arst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot), .s_axil_awvalid(s_axil_awvalid),
    .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
    .s_axil_rready(s_axil_rready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot), .m_axil_awvalid(m_axil_awvalid),
    .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb), .m_axil_wvalid(m_axil_wvalid),
    .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot), .m_axil_arvalid(m_axil_arvalid),
    .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
    .m_axil_rready(m_axil_rready)
  );

  // Record every beat that leaves the slice, in handshake order.
  always @(posedge aclk) begin
    if (m_axil_awvalid && m_axil_awready) aw_out.push_back(m_axil_awaddr);
    if (m_axil_wvalid && m_axil_wready) w_out.push_back(m_axil_wdata);
    if (m_axil_arvalid && m_axil_arready) ar_out.push_back(m_axil_araddr);
    if (s_axil_bvalid && s_axil_bready) b_out.push_back(s_axil_bresp);
  end

  task automatic test_reset;
    repeat (3) @(negedge aclk);
    checks++; if (m_axil_awvalid !== 1'b0 || m_axil_awaddr !== 32'h0) begin errors++;
      $display("FAIL reset_aw: valid=%b addr=%h, want 0/0", m_axil_awvalid, m_axil_awaddr); end
    checks++; if (s_axil_awready !== 1'b0 || s_axil_arready !== 1'b0 || s_axil_wready !== 1'b0) begin errors++;
      $display("FAIL reset_ready: aw=%b w=%b ar=%b, want 0", s_axil_awready, s_axil_wready, s_axil_arready); end
    checks++; if (s_axil_bvalid !== 1'b0 || m_axil_bready !== 1'b1) begin errors++;
      $display("FAIL reset_b: bvalid=%b bready=%b, want 0/1", s_axil_bvalid, m_axil_bready); end
    arst = 1'b0;
    @(negedge aclk);
    checks++; if (s_axil_awready !== 1'b1 || s_axil_arready !== 1'b1 || s_axil_wready !== 1'b1) begin errors++;
      $display("FAIL reset_release_ready: aw=%b w=%b ar=%b, want 1", s_axil_awready, s_axil_wready, s_axil_arready); end
  endtask

  task automatic test_aw_stream;
    logic [31:0] addrs [3] = '{32'h1000, 32'h1004, 32'h1008};
    m_axil_awready = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      @(negedge aclk);
      if (i > 0) begin
        checks++; if (m_axil_awvalid !== 1'b1 || m_axil_awaddr !== addrs[i-1]) begin errors++;
          $display("FAIL aw_stream[%0d]: valid=%b addr=%h, want 1/%h", i, m_axil_awvalid, m_axil_awaddr, addrs[i-1]); end
      end
      checks++; if (s_axil_awready !== 1'b1) begin errors++;
        $display("FAIL aw_ready[%0d]: got %b want 1", i, s_axil_awready); end
      s_axil_awvalid = (i < 3);
      s_axil_awaddr  = (i < 3) ? addrs[i] : 32'h0;
    end
    @(negedge aclk);
    checks++; if (m_axil_awvalid !== 1'b0 || m_axil_awaddr !== 32'h0) begin errors++;
      $display("FAIL aw_drain: valid=%b addr=%h, want 0/0", m_axil_awvalid, m_axil_awaddr); end
  endtask

  task automatic test_w_stall;
    logic [31:0] data [4] = '{32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003, 32'hA5A5_0004};
    int idx = 0;
    logic acc;
    w_out.delete();
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge aclk);
      if (cyc >= 1 && cyc <= 6) begin
        checks++; if (m_axil_wvalid !== 1'b1 || m_axil_wdata !== 32'hA5A5_0001 || m_axil_wstrb !== 4'hF) begin errors++;
          $display("FAIL w_stall_hold[%0d]: valid=%b data=%h strb=%h, want 1/a5a50001/f", cyc, m_axil_wvalid, m_axil_wdata, m_axil_wstrb); end
      end
      if (cyc == 1) begin
        checks++; if (s_axil_wready !== 1'b1) begin errors++;
          $display("FAIL w_ready_one: got %b want 1", s_axil_wready); end
      end
      if (cyc >= 2 && cyc <= 6) begin
        checks++; if (s_axil_wready !== 1'b0 || idx != 2) begin errors++;
          $display("FAIL w_ready_full[%0d]: ready=%b accepted=%0d, want 0/2", cyc, s_axil_wready, idx); end
      end
      m_axil_wready = (cyc >= 7);
      s_axil_wvalid = (idx < 4);
      s_axil_wdata  = (idx < 4) ? data[idx] : 32'h0;
      s_axil_wstrb  = 4'hF;
      #1;
      acc = s_axil_wvalid && s_axil_wready;
      @(posedge aclk);
      if (acc) idx++;
    end
    checks++; if (w_out.size() != 4) begin errors++;
      $display("FAIL w_count: got %0d want 4", w_out.size()); end
    for (int i = 0; i < 4 && i < w_out.size(); i++) begin
      checks++; if (w_out[i] !== data[i]) begin errors++;
        $display("FAIL w_order[%0d]: got %h want %h", i, w_out[i], data[i]); end
    end
    s_axil_wvalid = 1'b0;
  endtask

  task automatic test_b_toggle;
    logic [1:0] seq [4] = '{2'b10, 2'b01, 2'b11, 2'b00};
    int idx = 0;
    logic acc, stalled = 1'b0;
    logic [1:0] held = 2'b00;
    b_out.delete();
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge aclk);
      if (stalled) begin
        checks++; if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== held) begin errors++;
          $display("FAIL b_stable[%0d]: valid=%b resp=%b, want 1/%b", cyc, s_axil_bvalid, s_axil_bresp, held); end
      end
      m_axil_bvalid = (idx < 4);
      m_axil_bresp  = (idx < 4) ? seq[idx] : 2'b00;
      s_axil_bready = (cyc % 2 == 1);
      #1;
      acc     = m_axil_bvalid && m_axil_bready;
      stalled = s_axil_bvalid && !s_axil_bready;
      held    = s_axil_bresp;
      @(posedge aclk);
      if (acc) idx++;
    end
    checks++; if (b_out.size() != 4) begin errors++;
      $display("FAIL b_count: got %0d want 4", b_out.size()); end
    for (int i = 0; i < 4 && i < b_out.size(); i++) begin
      checks++; if (b_out[i] !== seq[i]) begin errors++;
        $display("FAIL b_order[%0d]: got %b want %b", i, b_out[i], seq[i]); end
    end
    m_axil_bvalid = 1'b0;
    s_axil_bready = 1'b0;
  endtask

  task automatic test_r_bypass;
    @(negedge aclk);
    m_axil_rvalid = 1'b1; m_axil_rdata = 32'hDEADBEEF; m_axil_rresp = 2'b01;
    #1;
    checks++; if (s_axil_rvalid !== 1'b1 || s_axil_rdata !== 32'hDEADBEEF || s_axil_rresp !== 2'b01) begin errors++;
      $display("FAIL r_bypass_data: valid=%b data=%h resp=%b, want 1/deadbeef/01", s_axil_rvalid, s_axil_rdata, s_axil_rresp); end
    s_axil_rready = 1'b1; #1;
    checks++; if (m_axil_rready !== 1'b1) begin errors++;
      $display("FAIL r_bypass_ready_hi: got %b want 1", m_axil_rready); end
    s_axil_rready = 1'b0; #1;
    checks++; if (m_axil_rready !== 1'b0) begin errors++;
      $display("FAIL r_bypass_ready_lo: got %b want 0", m_axil_rready); end
    m_axil_rvalid = 1'b0; #1;
    checks++; if (s_axil_rvalid !== 1'b0) begin errors++;
      $display("FAIL r_bypass_idle: got %b want 0", s_axil_rvalid); end
  endtask

  task automatic test_ar_reset_in_two;
    ar_out.delete();
    m_axil_arready = 1'b0;
    @(negedge aclk); s_axil_arvalid = 1'b1; s_axil_araddr = 32'h2000;
    @(negedge aclk); s_axil_araddr = 32'h2004;
    @(negedge aclk); s_axil_arvalid = 1'b0; s_axil_araddr = 32'h0;
    checks++; if (s_axil_arready !== 1'b0 || m_axil_arvalid !== 1'b1 || m_axil_araddr !== 32'h2000) begin errors++;
      $display("FAIL ar_two: ready=%b valid=%b addr=%h, want 0/1/2000", s_axil_arready, m_axil_arvalid, m_axil_araddr); end
    #2 arst = 1'b1;
    #1;
    checks++; if (m_axil_arvalid !== 1'b0 || m_axil_araddr !== 32'h0 || s_axil_arready !== 1'b0) begin errors++;
      $display("FAIL ar_async_reset: valid=%b addr=%h ready=%b, want 0/0/0", m_axil_arvalid, m_axil_araddr, s_axil_arready); end
    @(negedge aclk); arst = 1'b0;
    @(negedge aclk);
    checks++; if (s_axil_arready !== 1'b1 || m_axil_arvalid !== 1'b0) begin errors++;
      $display("FAIL ar_after_reset: ready=%b valid=%b, want 1/0", s_axil_arready, m_axil_arvalid); end
    m_axil_arready = 1'b1;
    repeat (3) @(negedge aclk);
    checks++; if (ar_out.size() != 0) begin errors++;
      $display("FAIL ar_no_stale: got %0d beats want 0", ar_out.size()); end
  endtask

  task automatic test_stress;
    localparam int N = 5000;
    logic [31:0] aw_q[$], ar_q[$];
    logic aw_acc = 1'b0, ar_acc = 1'b0;
    int cyc = 0;
    aw_out.delete(); ar_out.delete();
    while ((aw_out.size() < N || ar_out.size() < N) && cyc < 40000) begin
      @(negedge aclk);
      if (aw_acc) begin aw_q.push_back(s_axil_awaddr); s_axil_awvalid = 1'b0; end
      if (ar_acc) begin ar_q.push_back(s_axil_araddr); s_axil_arvalid = 1'b0; end
      if (!s_axil_awvalid && aw_q.size() < N && $urandom_range(0, 3) != 0) begin
        s_axil_awvalid = 1'b1; s_axil_awaddr = $urandom;
      end
      if (!s_axil_arvalid && ar_q.size() < N && $urandom_range(0, 3) != 0) begin
        s_axil_arvalid = 1'b1; s_axil_araddr = $urandom;
      end
      m_axil_awready = ($urandom_range(0, 2) != 0);
      m_axil_arready = ($urandom_range(0, 2) != 0);
      aw_acc = s_axil_awvalid && s_axil_awready;
      ar_acc = s_axil_arvalid && s_axil_arready;
      cyc++;
      @(posedge aclk);
    end
    checks++; if (aw_out.size() != N || aw_q.size() != N) begin errors++;
      $display("FAIL stress_aw_count: sent=%0d out=%0d want %0d", aw_q.size(), aw_out.size(), N); end
    checks++; if (ar_out.size() != N || ar_q.size() != N) begin errors++;
      $display("FAIL stress_ar_count: sent=%0d out=%0d want %0d", ar_q.size(), ar_out.size(), N); end
    for (int i = 0; i < aw_out.size() && i < aw_q.size(); i++) begin
      checks++; if (aw_out[i] !== aw_q[i]) begin errors++;
        $display("FAIL stress_aw[%0d]: got %h want %h", i, aw_out[i], aw_q[i]); end
    end
    for (int i = 0; i < ar_out.size() && i < ar_q.size(); i++) begin
      checks++; if (ar_out[i] !== ar_q[i]) begin errors++;
        $display("FAIL stress_ar[%0d]: got %h want %h", i, ar_out[i], ar_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_aw_stream();
    test_w_stall();
    test_b_toggle();
    test_r_bypass();
    test_ar_reset_in_two();
    test_stress();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
